// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - buffered instruction decoder with I2C-busy issue stall and branch flush
//
// Accepts raw instructions into a DEPTH-entry circular queue and decodes the
// queue head into a registered control bundle for the execute stage.
// Optional feature macro: DECODE_PIPE_ILLEGAL_TRAP_EN (sticky illegal trap).
//
// Ports:
//   i_clk, i_rst_n            clock (rising edge), asynchronous active-low reset
//   i_instr_valid/o_instr_ready/i_instr   fetch-side handshake and raw instruction
//   o_valid/i_ready           decoded bundle handshake to execute stage
//   o_dest, o_src, o_imm, o_addr          decoded operand fields
//   o_alu_ctrl, o_rd_wen, o_i2c_ctrl      decoded control fields
//   i_i2c_busy                I2C controller busy; stalls heads carrying an I2C command
//   i_flush                   taken branch: discard queue and output bundle
//   o_illegal                 sticky illegal-opcode flag (0 unless trap enabled)
module decode_pipe #(
    parameter int REG_AW = 4,
    parameter int IMM_W  = 8,
    parameter int DEPTH  = 4,
    localparam int INSTR_W = 5 + 2 * REG_AW + IMM_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_instr_valid,
    output logic               o_instr_ready,
    input  logic [INSTR_W-1:0] i_instr,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [REG_AW-1:0]  o_dest,
    output logic [REG_AW-1:0]  o_src,
    output logic [IMM_W-1:0]   o_imm,
    output logic [IMM_W-1:0]   o_addr,
    output logic [2:0]         o_alu_ctrl,
    output logic               o_rd_wen,
    output logic [2:0]         o_i2c_ctrl,
    input  logic               i_i2c_busy,
    input  logic               i_flush,
    output logic               o_illegal
);

    localparam int PW = $clog2(DEPTH) + 1;

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      count;
    logic               full;
    logic               empty;
    logic               push;
    logic               issue;
    logic               stall;
    logic               trap_block;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign count         = wr_ptr - rd_ptr;
    assign full          = (count == PW'(DEPTH));
    assign empty         = (wr_ptr == rd_ptr);
    assign o_instr_ready = !full;
    assign push          = i_instr_valid && !full && !i_flush;

    logic [INSTR_W-1:0] head;
    logic [4:0]         head_op;
    logic [REG_AW-1:0]  head_dest;
    logic [REG_AW-1:0]  head_src;
    logic [IMM_W-1:0]   head_imm;

    assign head      = mem[rd_ptr[PW-2:0]];
    assign head_op   = head[INSTR_W-1 -: 5];
    assign head_dest = head[INSTR_W-6 -: REG_AW];
    assign head_src  = head[IMM_W+REG_AW-1 -: REG_AW];
    assign head_imm  = head[IMM_W-1:0];

    logic [2:0] dec_alu;
    logic       dec_wen;
    logic [2:0] dec_i2c;
    logic       dec_legal;
    logic       dec_load;

    always_comb begin
        dec_alu   = 3'b000;
        dec_wen   = 1'b0;
        dec_i2c   = 3'b000;
        dec_legal = 1'b1;
        dec_load  = 1'b0;
        case (head_op)
            5'b00000: begin dec_alu = 3'b001; dec_wen = 1'b1; end // ADD
            5'b00010: begin dec_alu = 3'b010; dec_wen = 1'b1; end // SUB
            5'b00101: begin dec_alu = 3'b001; dec_wen = 1'b1; end // ADDI
            5'b00110: dec_i2c = 3'b001;                           // I2CSTART
            5'b01000: dec_i2c = 3'b010;                           // I2CSTOP
            5'b01010: begin dec_wen = 1'b1; dec_load = 1'b1; end  // LOAD
            5'b01100: dec_i2c = 3'b011;                           // SENDCON
            5'b01110: dec_i2c = 3'b100;                           // SENDI2C
            5'b10000: dec_wen = 1'b1;                             // SETFLAG
            5'b10011: dec_alu = 3'b011;                           // BEQ
            5'b10101: dec_alu = 3'b100;                           // BEQF
            5'b11111: ;                                           // NOP
            default:  dec_legal = 1'b0;
        endcase
    end

    // NOP and illegal opcodes both leave an all-zero bundle.
    logic nop_bundle;
    assign nop_bundle = !dec_legal || (head_op == 5'b11111);

    assign stall = (dec_i2c != 3'b000) && i_i2c_busy;
    assign issue = !empty && (!o_valid || i_ready) && !stall && !i_flush && !trap_block;

`ifdef DECODE_PIPE_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            illegal_q <= 1'b0;
        end else if (i_flush) begin
            illegal_q <= 1'b0;
        end else if (issue && !dec_legal) begin
            illegal_q <= 1'b1;
        end
    end
    assign trap_block = illegal_q;
    assign o_illegal  = illegal_q;
`else
    assign trap_block = 1'b0;
    assign o_illegal  = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr[PW-2:0]] <= i_instr;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + 1'b1;
            if (issue) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Bundle fields only change on issue; flush and drain leave them as-is.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid    <= 1'b0;
            o_dest     <= '0;
            o_src      <= '0;
            o_imm      <= '0;
            o_addr     <= '0;
            o_alu_ctrl <= '0;
            o_rd_wen   <= 1'b0;
            o_i2c_ctrl <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (issue) begin
            o_valid <= 1'b1;
            if (nop_bundle) begin
                o_dest     <= '0;
                o_src      <= '0;
                o_imm      <= '0;
                o_addr     <= '0;
                o_alu_ctrl <= '0;
                o_rd_wen   <= 1'b0;
                o_i2c_ctrl <= '0;
            end else begin
                o_dest     <= head_dest;
                o_src      <= dec_load ? '0 : head_src;
                o_imm      <= head_op[0] ? head_imm : '0;
                o_addr     <= dec_load ? {{(IMM_W/2){1'b0}}, head_imm[IMM_W-1:IMM_W/2]} : '0;
                o_alu_ctrl <= dec_alu;
                o_rd_wen   <= dec_wen;
                o_i2c_ctrl <= dec_i2c;
            end
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule
